fifo_4x_dual_chan_ctrl: RTL and testbench
=========================================

Name: fifo_4x_dual_chan_ctrl

Overview:
- Controller that sequences the shared 9-bit, 256-entry dual-port FIFO macro `fifo_4x_swrite_sread` as two logical 128-entry channels.
- Owns the macro's WADDR/RADDR/DIn/WRB/RDB/DC_in* pins.
- Round-robin arbitrates two producers onto the single write port and two consumers onto the single read port.
- Keeps per-channel pointers, occupancy and status flags.
- Sits between the APB-side request logic and the macro; the macro's WCLKS/RCLKS are tied to CLK at the parent.

Parameters:
- DW, 9, data width (matches macro DIn/DO).
- AW, 8, macro address width; the MSB selects the channel, the low AW-1 bits are the in-channel pointer.
- THRESH, 64, per-channel occupancy threshold for the EQTH/GEQTH flags (1..128).
- DC_MODE, 3'b000, static value driven on macro DC_in2..DC_in0.

Ports:
- CLK  in  1  single clock for controller and macro.
- RST  in  1  synchronous, active-high reset.
- WREQ  in  2  per-channel write request.
- WD0  in  DW  channel 0 write data.
- WD1  in  DW  channel 1 write data.
- WGNT  out  2  one-hot write grant, combinational, same cycle as accept.
- RREQ  in  2  per-channel read request.
- RGNT  out  2  one-hot read grant, combinational.
- RVALID  out  1  read data valid.
- RCH  out  1  channel of the returned data.
- RDATA  out  DW  returned data.
- FLUSH  in  2  per-channel synchronous flush.
- FULL  out  2  count==128.
- EMPTY  out  2  count==0.
- EQTH  out  2  count==THRESH.
- GEQTH  out  2  count>=THRESH.
- M_DIN  out  DW  to macro DIn.
- M_WADDR  out  AW  to macro WADDR.
- M_RADDR  out  AW  to macro RADDR.
- M_WRB  out  1  to macro WRB, active-low.
- M_RDB  out  1  to macro RDB, active-low.
- M_DC  out  3  to macro DC_in2..DC_in0.
- M_DO1  in  DW  from macro DO1.

Behaviour:
- Reset (CLK edge with RST=1): all pointers and counts = 0; M_WRB=M_RDB=1; M_WADDR=M_RADDR=0; M_DIN=0; RVALID=0; RCH=0; RDATA=0; both round-robin pointers favour channel 0.
- Reset overrides everything; in-flight reads are dropped and produce no RVALID.
- Flags: during reset and after it, EMPTY=2'b11, FULL=0, GEQTH=0, EQTH=0. Flags are decoded from the registered counts.
- Per-channel state: wptr[6:0], rptr[6:0], cnt[7:0] (0..128). Pointers wrap 127→0. Macro address = {ch, ptr}.
- Write arbitration:
  - A channel is eligible when WREQ[c]=1 and FULL[c]=0.
  - At most one grant per cycle. On a tie, grant the channel that was not granted last; the rr pointer updates only when a grant occurs.
  - On grant at cycle T: the cycle-T edge registers M_DIN=WDc, M_WADDR={c,wptr}, M_WRB=0 for exactly one cycle (T+1); wptr increments.
  - A write request to a full channel is not granted and has no effect.
- Read arbitration:
  - Same rr scheme over RREQ[c] & !EMPTY[c].
  - On grant at T: M_RADDR={c,rptr} and M_RDB=0 registered for cycle T+1; rptr increments.
  - At the end of T+1, RDATA<=M_DO1, RCH<=c and RVALID=1 during T+2. Fixed latency is 2; back-to-back grants give back-to-back RVALID.
- Count update at the grant edge:
  - write only: +1; read only: −1; write and read on the same channel: unchanged.
  - Eligibility uses the pre-edge count. A read and a write of the same channel may therefore both be granted when 0<cnt<128.
  - Read-after-write ordering is safe because a read is granted only when cnt>0, and every counted entry has an earlier macro write.
- FLUSH[c]:
  - Clears wptr/rptr/cnt of channel c at the edge and suppresses any same-cycle grant to c (WGNT[c]=RGNT[c]=0).
  - A read already issued still returns its RVALID.
  - The other channel is unaffected.
- M_DC = DC_MODE constantly. The macro's own FULLx/EMPTYx/EQTHx/GEQTHx outputs are unused; the controller's flags are authoritative.
- Both write and read ports may be active in the same cycle, on the same or different channels.

Decomposition:
- Shared package fifo_4x_ctrl_pkg:
  - constants DW=9, AW=8, CH_DEPTH=128, CNT_W=8;
  - typedef chan_state_t {wptr, rptr, cnt}.
- One sub-module, rr_arb2: 2-requester round-robin arbiter with a grant-enable input.
  - Instantiated twice, once for writes and once for reads.
  - Channel state update lives in the top module.

Test Plan:
- Reset, then WREQ=01 ×3 with WD0=0x1A5, 0x0FF, 0x001 -> M_WRB low for 3 cycles at M_WADDR 0x00, 0x01, 0x02; cnt0=3; EMPTY=10.
- WREQ=11 held for 4 cycles -> WGNT alternates 01, 10, 01, 10; M_WADDR 0x00, 0x80, 0x01, 0x81.
- Fill ch1 with 128 writes -> FULL[1]=1 and a further WREQ[1] gives no grant. Then RREQ=10 once -> RGNT=10 and RVALID 2 cycles later with RCH=1 and the first-written data. FULL[1] clears in the cycle after the read grant.
- cnt0=1, with WREQ[0] and RREQ[0] in the same cycle -> both granted, cnt0 stays 1, and the data read back is the older entry.
- Fill ch0 to 64 -> EQTH[0]=GEQTH[0]=1; the 65th write -> EQTH[0]=0, GEQTH[0]=1.
- With a read in flight on ch0, assert FLUSH[0] together with WREQ[0] -> no grant that cycle; RVALID still arrives; cnt0=0, EMPTY[0]=1, the next write goes to 0x00. Asserting RST mid-read -> no RVALID.

Source files
------------

// File: rtl/fifo_4x_dual_chan_ctrl_pkg.sv
// Shared constants and per-channel state for the dual-channel FIFO macro controller.
package fifo_4x_ctrl_pkg;

  localparam int DW       = 9;
  localparam int AW       = 8;
  localparam int CH_DEPTH = 128;
  localparam int CNT_W    = 8;
  localparam int PTR_W    = $clog2(CH_DEPTH);

  typedef struct packed {
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
  } chan_state_t;

endpackage

// File: rtl/fifo_4x_dual_chan_ctrl_if.sv
// Client-side request/grant/status bundle between the APB request logic and the controller.
interface fifo_4x_dual_chan_ctrl_if
  import fifo_4x_ctrl_pkg::*;
#(
  parameter int DW = fifo_4x_ctrl_pkg::DW
);
  logic [1:0]    WREQ;
  logic [DW-1:0] WD0;
  logic [DW-1:0] WD1;
  logic [1:0]    WGNT;
  logic [1:0]    RREQ;
  logic [1:0]    RGNT;
  logic          RVALID;
  logic          RCH;
  logic [DW-1:0] RDATA;
  logic [1:0]    FLUSH;
  logic [1:0]    FULL;
  logic [1:0]    EMPTY;
  logic [1:0]    EQTH;
  logic [1:0]    GEQTH;

  modport master (
    output WREQ, WD0, WD1, RREQ, FLUSH,
    input  WGNT, RGNT, RVALID, RCH, RDATA, FULL, EMPTY, EQTH, GEQTH
  );

  modport slave (
    input  WREQ, WD0, WD1, RREQ, FLUSH,
    output WGNT, RGNT, RVALID, RCH, RDATA, FULL, EMPTY, EQTH, GEQTH
  );
endinterface

// File: rtl/fifo_4x_dual_chan_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; combinational one-hot grant, pointer moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  // last = index of the most recent winner; reset to 1 so channel 0 wins the first tie
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/fifo_4x_dual_chan_ctrl.sv
// Splits the 256-entry single-write/single-read FIFO macro into two 128-entry channels
// with round-robin access, per-channel pointers/counts and registered-count status flags.
module fifo_4x_dual_chan_ctrl
  import fifo_4x_ctrl_pkg::*;
#(
  parameter int         DW      = fifo_4x_ctrl_pkg::DW,
  parameter int         AW      = fifo_4x_ctrl_pkg::AW,
  parameter int         THRESH  = 64,
  parameter logic [2:0] DC_MODE = 3'b000
) (
  input  logic                    CLK,
  input  logic                    RST,
  fifo_4x_dual_chan_ctrl_if.slave bus,
  output logic [DW-1:0]           M_DIN,
  output logic [AW-1:0]           M_WADDR,
  output logic [AW-1:0]           M_RADDR,
  output logic                    M_WRB,
  output logic                    M_RDB,
  output logic [2:0]              M_DC,
  input  logic [DW-1:0]           M_DO1
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CH_DEPTH);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

  chan_state_t st [2];
  logic [1:0]  full, empty, w_elig, r_elig, wgnt, rgnt;
  logic        wch, rch_g, wr, rd;
  logic [2:1]  vld_pipe;
  logic [2:1]  ch_pipe;

  always_comb begin
    full      = '0;
    empty     = '0;
    bus.EQTH  = '0;
    bus.GEQTH = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]      = (st[c].cnt == FULL_CNT);
      empty[c]     = (st[c].cnt == '0);
      bus.EQTH[c]  = (st[c].cnt == THR);
      bus.GEQTH[c] = (st[c].cnt >= THR);
    end
  end

  assign bus.FULL  = full;
  assign bus.EMPTY = empty;

  // A flushing channel must not be granted in the same cycle it is cleared
  assign w_elig = bus.WREQ & ~full  & ~bus.FLUSH;
  assign r_elig = bus.RREQ & ~empty & ~bus.FLUSH;

  rr_arb2 u_warb (.clk(CLK), .rst(RST), .req(w_elig), .en(!RST), .gnt(wgnt));
  rr_arb2 u_rarb (.clk(CLK), .rst(RST), .req(r_elig), .en(!RST), .gnt(rgnt));

  assign bus.WGNT = wgnt;
  assign bus.RGNT = rgnt;
  assign wch      = wgnt[1];
  assign rch_g    = rgnt[1];
  assign wr       = |wgnt;
  assign rd       = |rgnt;
  assign M_DC     = DC_MODE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < 2; c++) st[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (bus.FLUSH[c]) begin
          st[c] <= '0;
        end else begin
          if (wgnt[c]) st[c].wptr <= st[c].wptr + 1'b1;
          if (rgnt[c]) st[c].rptr <= st[c].rptr + 1'b1;
          case ({wgnt[c], rgnt[c]})
            2'b10:   st[c].cnt <= st[c].cnt + 1'b1;
            2'b01:   st[c].cnt <= st[c].cnt - 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Macro pin stage: address/data held from the last access, strobes pulse one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      M_DIN   <= '0;
      M_WADDR <= '0;
      M_RADDR <= '0;
      M_WRB   <= 1'b1;
      M_RDB   <= 1'b1;
    end else begin
      M_WRB <= ~wr;
      M_RDB <= ~rd;
      if (wr) begin
        M_DIN   <= wch ? bus.WD1 : bus.WD0;
        M_WADDR <= {wch, st[wch].wptr};
      end
      if (rd) M_RADDR <= {rch_g, st[rch_g].rptr};
    end
  end

  // Read return: grant -> macro read cycle -> data captured, valid two cycles after grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe  <= '0;
      ch_pipe   <= '0;
      bus.RDATA <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd};
      ch_pipe  <= {ch_pipe[1], rch_g};
      if (vld_pipe[1]) bus.RDATA <= M_DO1;
    end
  end

  assign bus.RVALID = vld_pipe[2];
  assign bus.RCH    = ch_pipe[2];
endmodule

// File: tb/tb_fifo_4x_dual_chan_ctrl.sv
// Directed bench: behavioural 256x9 macro model plus hand-computed expectations per scenario.
module tb_fifo_4x_dual_chan_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic [8:0] M_DIN, M_DO1;
  logic [7:0] M_WADDR, M_RADDR;
  logic       M_WRB, M_RDB;
  logic [2:0] M_DC;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_4x_dual_chan_ctrl_if bus ();

  fifo_4x_dual_chan_ctrl dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .M_DIN(M_DIN), .M_WADDR(M_WADDR), .M_RADDR(M_RADDR),
    .M_WRB(M_WRB), .M_RDB(M_RDB), .M_DC(M_DC), .M_DO1(M_DO1)
  );

  always #5 CLK = ~CLK;

  logic [8:0] mem [256];
  always @(posedge CLK) if (!M_WRB) mem[M_WADDR] <= M_DIN;
  assign M_DO1 = mem[M_RADDR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    bus.WREQ = '0; bus.RREQ = '0; bus.FLUSH = '0; bus.WD0 = '0; bus.WD1 = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  logic [8:0] v1 [3];

  initial begin
    v1[0] = 9'h1A5; v1[1] = 9'h0FF; v1[2] = 9'h001;
    idle();
    RST = 1'b1; tick(); tick();
    chk("rst_empty", bus.EMPTY, 2'b11);
    chk("rst_full",  bus.FULL,  2'b00);
    chk("rst_geqth", bus.GEQTH, 2'b00);
    chk("rst_eqth",  bus.EQTH,  2'b00);
    chk("rst_wrb",   M_WRB, 1'b1);
    chk("rst_rdb",   M_RDB, 1'b1);
    chk("rst_waddr", M_WADDR, 8'h00);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_rdata", bus.RDATA, 9'h000);
    chk("dc_mode",   M_DC, 3'b000);
    RST = 1'b0;

    // three writes to ch0
    for (int i = 0; i < 3; i++) begin
      bus.WREQ = 2'b01; bus.WD0 = v1[i]; #1;
      chk("t1_wgnt", bus.WGNT, 2'b01);
      tick();
      chk("t1_wrb",   M_WRB, 1'b0);
      chk("t1_waddr", M_WADDR, 32'(i));
      chk("t1_din",   M_DIN, v1[i]);
    end
    bus.WREQ = 2'b00; tick();
    chk("t1_wrb_idle", M_WRB, 1'b1);
    chk("t1_empty",    bus.EMPTY, 2'b10);

    // alternating grants on a held tie
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.WREQ = 2'b11; bus.WD0 = 9'(9'h10 + i); bus.WD1 = 9'(9'h20 + i); #1;
      chk("t2_wgnt", bus.WGNT, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk("t2_waddr", M_WADDR, ((i % 2) ? 8'h80 : 8'h00) + 8'(i / 2));
      chk("t2_din",   M_DIN, (i % 2) ? 9'(9'h20 + i) : 9'(9'h10 + i));
    end
    bus.WREQ = 2'b00;

    // fill ch1 (already holds 0x21, 0x23)
    for (int i = 2; i < 128; i++) begin
      bus.WREQ = 2'b10; bus.WD1 = 9'(i);
      if (i == 127) begin #1; chk("t3_notfull", bus.FULL, 2'b00); end
      tick();
    end
    chk("t3_full", bus.FULL, 2'b10);
    bus.WREQ = 2'b10; bus.WD1 = 9'h1FF; #1;
    chk("t3_full_nogrant", bus.WGNT, 2'b00);
    tick();
    chk("t3_full_nowrite", M_WRB, 1'b1);
    bus.WREQ = 2'b00; bus.RREQ = 2'b10; #1;
    chk("t3_rgnt", bus.RGNT, 2'b10);
    tick();
    bus.RREQ = 2'b00;
    chk("t3_rdb",    M_RDB, 1'b0);
    chk("t3_raddr",  M_RADDR, 8'h80);
    chk("t3_fullclr", bus.FULL, 2'b00);
    chk("t3_rvalid_early", bus.RVALID, 1'b0);
    tick();
    chk("t3_rvalid", bus.RVALID, 1'b1);
    chk("t3_rch",    bus.RCH, 1'b1);
    chk("t3_rdata",  bus.RDATA, 9'h021);
    tick();
    chk("t3_rvalid_drop", bus.RVALID, 1'b0);

    // ch0 holds 0x10, 0x12: read one, then same-cycle write+read at cnt0=1
    bus.RREQ = 2'b01; #1;
    chk("t4_rgnt0", bus.RGNT, 2'b01);
    tick(); bus.RREQ = 2'b00; tick();
    chk("t4_rdata0", bus.RDATA, 9'h010);
    chk("t4_rch0",   bus.RCH, 1'b0);
    bus.WREQ = 2'b01; bus.WD0 = 9'h155; bus.RREQ = 2'b01; #1;
    chk("t4_wgnt", bus.WGNT, 2'b01);
    chk("t4_rgnt", bus.RGNT, 2'b01);
    tick();
    bus.WREQ = 2'b00; bus.RREQ = 2'b00;
    chk("t4_waddr", M_WADDR, 8'h02);
    chk("t4_raddr", M_RADDR, 8'h01);
    chk("t4_strobes", {M_WRB, M_RDB}, 2'b00);
    chk("t4_empty", bus.EMPTY, 2'b00);
    tick();
    chk("t4_rvalid", bus.RVALID, 1'b1);
    chk("t4_rdata",  bus.RDATA, 9'h012);
    bus.RREQ = 2'b01; #1;
    chk("t4_rgnt_last", bus.RGNT, 2'b01);
    tick(); bus.RREQ = 2'b00;
    chk("t4_empty_after", bus.EMPTY, 2'b01);
    tick();
    chk("t4_rdata_last", bus.RDATA, 9'h155);

    // threshold flags
    do_reset();
    for (int i = 0; i < 65; i++) begin
      bus.WREQ = 2'b01; bus.WD0 = 9'(i + 5);
      tick();
      if (i == 62) begin
        chk("t5_eqth63",  bus.EQTH,  2'b00);
        chk("t5_geqth63", bus.GEQTH, 2'b00);
      end
      if (i == 63) begin
        chk("t5_eqth64",  bus.EQTH,  2'b01);
        chk("t5_geqth64", bus.GEQTH, 2'b01);
      end
      if (i == 64) begin
        chk("t5_eqth65",  bus.EQTH,  2'b00);
        chk("t5_geqth65", bus.GEQTH, 2'b01);
      end
    end
    bus.WREQ = 2'b00;

    // flush with a read in flight
    bus.RREQ = 2'b01; #1;
    chk("t6_rgnt", bus.RGNT, 2'b01);
    tick();
    bus.RREQ = 2'b00; bus.FLUSH = 2'b01; bus.WREQ = 2'b01; bus.WD0 = 9'h077; #1;
    chk("t6_flush_nogrant", bus.WGNT, 2'b00);
    tick();
    chk("t6_rvalid", bus.RVALID, 1'b1);
    chk("t6_rdata",  bus.RDATA, 9'h005);
    chk("t6_empty",  bus.EMPTY, 2'b11);
    chk("t6_nowrite", M_WRB, 1'b1);
    bus.FLUSH = 2'b00; #1;
    chk("t6_wgnt_after", bus.WGNT, 2'b01);
    tick();
    bus.WREQ = 2'b00;
    chk("t6_waddr", M_WADDR, 8'h00);
    chk("t6_wrb",   M_WRB, 1'b0);
    chk("t6_empty2", bus.EMPTY, 2'b10);

    // reset with a read in flight drops it
    bus.RREQ = 2'b01; #1;
    chk("t7_rgnt", bus.RGNT, 2'b01);
    tick();
    bus.RREQ = 2'b00; RST = 1'b1;
    tick();
    chk("t7_rvalid_a", bus.RVALID, 1'b0);
    RST = 1'b0;
    tick();
    chk("t7_rvalid_b", bus.RVALID, 1'b0);
    chk("t7_empty",    bus.EMPTY, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
